// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS-subset core: encodings, ALU ops,
// forwarding selects and the four pipeline-register layouts.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h04;
    localparam logic [5:0] FN_SUB = 6'h05;
    localparam logic [5:0] FN_AND = 6'h06;
    localparam logic [5:0] FN_OR  = 6'h07;
    localparam logic [5:0] FN_XOR = 6'h08;
    localparam logic [5:0] FN_SLT = 6'h09;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EX_MEM,
        FWD_MEM_WB
    } fwd_sel_e;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [7:0]  pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] wb_data;
        logic        reg_write;
    } mem_wb_t;

    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_pipeline_core_if.sv
// Program-load port and writeback observation port of the MIPS core.
interface mips_pipeline_core_if;
    logic        ProgMode;
    logic [7:0]  Addr_Prog;
    logic [31:0] Data_Prog;
    logic [7:0]  pc_out;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // No handshake: ProgMode/Addr_Prog/Data_Prog are sampled every rising edge,
    // and the wb_* outputs describe the register write happening in the current cycle.
    modport master (
        output ProgMode, Addr_Prog, Data_Prog,
        input  pc_out, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  ProgMode, Addr_Prog, Data_Prog,
        output pc_out, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/mips_hazard_unit.sv
// Forwarding selects for the EX operands, load-use stall and branch flush.
module mips_hazard_unit
    import mips_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_dest,
    input  logic       ex_load,
    input  logic [4:0] mem_dest,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_dest,
    input  logic       wb_reg_write,
    input  logic       branch_taken,
    output fwd_sel_e   fwd_a,
    output fwd_sel_e   fwd_b,
    output logic       stall,
    output logic       flush
);

    logic load_use;

    // The younger producer (EX/MEM) wins over MEM/WB when both match.
    always_comb begin
        fwd_a = FWD_NONE;
        if (mem_reg_write && mem_dest != 5'd0 && mem_dest == ex_rs) begin
            fwd_a = FWD_EX_MEM;
        end else if (wb_reg_write && wb_dest != 5'd0 && wb_dest == ex_rs) begin
            fwd_a = FWD_MEM_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_NONE;
        if (mem_reg_write && mem_dest != 5'd0 && mem_dest == ex_rt) begin
            fwd_b = FWD_EX_MEM;
        end else if (wb_reg_write && wb_dest != 5'd0 && wb_dest == ex_rt) begin
            fwd_b = FWD_MEM_WB;
        end
    end

    assign load_use = ex_load && ex_dest != 5'd0 &&
                      ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));

    // A taken branch squashes the waiting consumer anyway, so it beats the stall.
    assign flush = branch_taken;
    assign stall = load_use && !branch_taken;

endmodule

// File: rtl/mips_pipeline_core.sv
// 5-stage MIPS-subset core (IF/ID/EX/MEM/WB) with program-loadable instruction
// memory, data memory, forwarding, load-use stall and EX-resolved branches.
module mips_pipeline_core
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_pipeline_core_if.slave  bus
);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] regs [32];

    logic [7:0] pc;
    if_id_t     if_id;
    id_ex_t     id_ex;
    ex_mem_t    ex_mem;
    mem_wb_t    mem_wb;

    logic hold;
    assign hold = reset || !bus.ProgMode;

    // ---------------- ID: decode and register read ----------------
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [4:0]  id_dest;
    logic        id_writes;
    logic        id_uses_rs;
    logic        id_uses_rt;
    id_ex_t      dec;
    logic        unused_shamt;

    assign id_opcode    = if_id.instr[31:26];
    assign id_rs        = if_id.instr[25:21];
    assign id_rt        = if_id.instr[20:16];
    assign id_rd        = if_id.instr[15:11];
    assign id_funct     = if_id.instr[5:0];
    assign unused_shamt = ^if_id.instr[10:6];

    // WB result is bypassed so ID sees the value written this same cycle.
    assign id_rs_val = (id_rs == 5'd0) ? 32'd0 :
                       (mem_wb.reg_write && mem_wb.dest == id_rs) ? mem_wb.wb_data : regs[id_rs];
    assign id_rt_val = (id_rt == 5'd0) ? 32'd0 :
                       (mem_wb.reg_write && mem_wb.dest == id_rt) ? mem_wb.wb_data : regs[id_rt];

    always_comb begin
        dec        = '0;
        dec.pc     = if_id.pc;
        dec.rs     = id_rs;
        dec.rt     = id_rt;
        dec.imm    = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
        dec.rs_val = id_rs_val;
        dec.rt_val = id_rt_val;
        dec.alu_op = ALU_ADD;
        id_dest    = id_rt;
        id_writes  = 1'b0;
        id_uses_rs = 1'b0;
        id_uses_rt = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                id_dest    = id_rd;
                id_writes  = 1'b1;
                id_uses_rs = 1'b1;
                id_uses_rt = 1'b1;
                case (id_funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: begin
                        id_writes  = 1'b0;
                        id_uses_rs = 1'b0;
                        id_uses_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                id_writes   = 1'b1;
                id_uses_rs  = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_LW: begin
                id_writes    = 1'b1;
                id_uses_rs   = 1'b1;
                dec.use_imm  = 1'b1;
                dec.mem_read = 1'b1;
            end
            OP_SW: begin
                id_uses_rs    = 1'b1;
                id_uses_rt    = 1'b1;
                dec.use_imm   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                id_uses_rs    = 1'b1;
                id_uses_rt    = 1'b1;
                dec.is_branch = 1'b1;
            end
            default: ;
        endcase
        // Writes to r0 are dropped at decode so they never show on wb_en.
        dec.reg_write = id_writes && (id_dest != 5'd0);
        dec.dest      = dec.reg_write ? id_dest : 5'd0;
    end

    // ---------------- EX: forwarding, ALU, branch ----------------
    fwd_sel_e    fwd_a;
    fwd_sel_e    fwd_b;
    logic        stall;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [7:0]  branch_target;

    always_comb begin
        case (fwd_a)
            FWD_EX_MEM: op_a = ex_mem.alu_result;
            FWD_MEM_WB: op_a = mem_wb.wb_data;
            default:    op_a = id_ex.rs_val;
        endcase
        case (fwd_b)
            FWD_EX_MEM: op_b = ex_mem.alu_result;
            FWD_MEM_WB: op_b = mem_wb.wb_data;
            default:    op_b = id_ex.rt_val;
        endcase
    end

    assign alu_result    = alu_eval(id_ex.alu_op, op_a, id_ex.use_imm ? id_ex.imm : op_b);
    assign branch_taken  = id_ex.is_branch && (op_a == op_b);
    assign branch_target = id_ex.pc + 8'd1 + id_ex.imm[7:0];

    mips_hazard_unit u_hazard (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_rs         (id_ex.rs),
        .ex_rt         (id_ex.rt),
        .ex_dest       (id_ex.dest),
        .ex_load       (id_ex.mem_read && id_ex.reg_write),
        .mem_dest      (ex_mem.dest),
        .mem_reg_write (ex_mem.reg_write),
        .wb_dest       (mem_wb.dest),
        .wb_reg_write  (mem_wb.reg_write),
        .branch_taken  (branch_taken),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall         (stall),
        .flush         (flush)
    );

    // ---------------- MEM ----------------
    logic [31:0] mem_result;
    assign mem_result = ex_mem.mem_read ? dmem[ex_mem.alu_result[7:0]] : ex_mem.alu_result;

    always_ff @(posedge clk) begin
        if (!hold && ex_mem.mem_write) begin
            dmem[ex_mem.alu_result[7:0]] <= ex_mem.store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.ProgMode) begin
            imem[bus.Addr_Prog] <= bus.Data_Prog;
        end
    end

    // ---------------- Register file ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (mem_wb.reg_write) begin
            regs[mem_wb.dest] <= mem_wb.wb_data;
        end
    end

    // ---------------- Pipeline registers and PC ----------------
    always_ff @(posedge clk) begin
        if (hold) begin
            pc     <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.dest       <= ex_mem.reg_write ? ex_mem.dest : 5'd0;
            mem_wb.wb_data    <= ex_mem.reg_write ? mem_result : 32'd0;

            ex_mem.dest       <= id_ex.dest;
            ex_mem.alu_result <= alu_result;
            ex_mem.store_data <= op_b;
            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_read   <= id_ex.mem_read;
            ex_mem.mem_write  <= id_ex.mem_write;

            if (flush) begin
                pc    <= branch_target;
                if_id <= '0;
                id_ex <= '0;
            end else if (stall) begin
                id_ex <= '0;
            end else begin
                pc          <= pc + 8'd1;
                if_id.pc    <= pc;
                if_id.instr <= imem[pc];
                id_ex       <= dec;
            end
        end
    end

    assign bus.pc_out  = pc;
    assign bus.wb_en   = mem_wb.reg_write;
    assign bus.wb_addr = mem_wb.dest;
    assign bus.wb_data = mem_wb.wb_data;

endmodule

// File: tb/tb_mips_pipeline_core.sv
// Directed bench for mips_pipeline_core: loads small programs and checks the
// writeback port and pc_out cycle by cycle against hand-derived traces.
module tb_mips_pipeline_core;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] prog_buf [32];
    logic        en_t   [32];
    logic [4:0]  addr_t [32];
    logic [31:0] data_t [32];
    logic [7:0]  pc_t   [32];

    mips_pipeline_core_if bus ();

    mips_pipeline_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog_buf[i] = 32'h0;
    endtask

    task automatic load_prog();
        bus.ProgMode = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.Addr_Prog = 8'(i);
            bus.Data_Prog = prog_buf[i];
            @(posedge clk);
            #1;
        end
    endtask

    // After this returns, the next negedge is cycle c0 (PC=0 fetched).
    task automatic start_run();
        reset = 1'b1;
        bus.ProgMode = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en_t[i]   = bus.wb_en;
            addr_t[i] = bus.wb_addr;
            data_t[i] = bus.wb_data;
            pc_t[i]   = bus.pc_out;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.ProgMode = 1'b1;
        bus.Addr_Prog = 8'h0;
        bus.Data_Prog = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 8'd0 || bus.wb_en !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pc=%0d en=%0b addr=%0d data=%0h, expected all zero",
                     bus.pc_out, bus.wb_en, bus.wb_addr, bus.wb_data);
        end
    endtask

    task automatic test_program_run();
        logic e_en;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        clear_prog();
        prog_buf[0] = 32'h10200005;
        prog_buf[1] = 32'h10400003;
        prog_buf[2] = 32'h00000004;
        prog_buf[3] = 32'h00811005;
        prog_buf[4] = 32'h00211004;
        load_prog();
        start_run();
        run_trace(10);
        for (int c = 0; c < 10; c++) begin
            case (c)
                7:       begin e_en = 1'b1; e_addr = 5'd2; e_data = 32'd3; end
                8:       begin e_en = 1'b1; e_addr = 5'd2; e_data = 32'd2; end
                default: begin e_en = 1'b0; e_addr = 5'd0; e_data = 32'd0; end
            endcase
            checks++;
            if (en_t[c] !== e_en || (e_en && (addr_t[c] !== e_addr || data_t[c] !== e_data))) begin
                errors++;
                $display("FAIL prog_wb c%0d: got en=%0b addr=%0d data=%0h, expected en=%0b addr=%0d data=%0h",
                         c, en_t[c], addr_t[c], data_t[c], e_en, e_addr, e_data);
            end
            checks++;
            if (pc_t[c] !== 8'(c)) begin
                errors++;
                $display("FAIL prog_pc c%0d: got %0d expected %0d", c, pc_t[c], c);
            end
        end
    endtask

    task automatic test_forward_chain();
        logic e_en;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        clear_prog();
        prog_buf[0] = 32'h20050007;  // ADDI r5,r0,7
        prog_buf[1] = 32'h00A53004;  // ADD  r6,r5,r5
        prog_buf[2] = 32'h00C53804;  // ADD  r7,r6,r5
        load_prog();
        start_run();
        run_trace(8);
        for (int c = 0; c < 8; c++) begin
            case (c)
                4:       begin e_en = 1'b1; e_addr = 5'd5; e_data = 32'd7;  end
                5:       begin e_en = 1'b1; e_addr = 5'd6; e_data = 32'd14; end
                6:       begin e_en = 1'b1; e_addr = 5'd7; e_data = 32'd21; end
                default: begin e_en = 1'b0; e_addr = 5'd0; e_data = 32'd0;  end
            endcase
            checks++;
            if (en_t[c] !== e_en || (e_en && (addr_t[c] !== e_addr || data_t[c] !== e_data))) begin
                errors++;
                $display("FAIL fwd_wb c%0d: got en=%0b addr=%0d data=%0d, expected en=%0b addr=%0d data=%0d",
                         c, en_t[c], addr_t[c], data_t[c], e_en, e_addr, e_data);
            end
            checks++;
            if (pc_t[c] !== 8'(c)) begin
                errors++;
                $display("FAIL fwd_pc c%0d: got %0d expected %0d", c, pc_t[c], c);
            end
        end
    endtask

    task automatic test_load_use();
        logic e_en;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        logic [7:0] e_pc;
        clear_prog();
        prog_buf[0] = 32'hAC030000;  // SW   r3,0(r0)
        prog_buf[1] = 32'h8C080000;  // LW   r8,0(r0)
        prog_buf[2] = 32'h01084804;  // ADD  r9,r8,r8
        prog_buf[3] = 32'h200A0055;  // ADDI r10,r0,0x55
        prog_buf[4] = 32'hAC0A0004;  // SW   r10,4(r0)
        prog_buf[5] = 32'h8C0B0004;  // LW   r11,4(r0)
        load_prog();
        start_run();
        run_trace(12);
        for (int c = 0; c < 12; c++) begin
            case (c)
                5:       begin e_en = 1'b1; e_addr = 5'd8;  e_data = 32'd3;  end
                7:       begin e_en = 1'b1; e_addr = 5'd9;  e_data = 32'd6;  end
                8:       begin e_en = 1'b1; e_addr = 5'd10; e_data = 32'h55; end
                10:      begin e_en = 1'b1; e_addr = 5'd11; e_data = 32'h55; end
                default: begin e_en = 1'b0; e_addr = 5'd0;  e_data = 32'd0;  end
            endcase
            e_pc = (c < 4) ? 8'(c) : 8'(c - 1);
            checks++;
            if (en_t[c] !== e_en || (e_en && (addr_t[c] !== e_addr || data_t[c] !== e_data))) begin
                errors++;
                $display("FAIL lduse_wb c%0d: got en=%0b addr=%0d data=%0h, expected en=%0b addr=%0d data=%0h",
                         c, en_t[c], addr_t[c], data_t[c], e_en, e_addr, e_data);
            end
            checks++;
            if (pc_t[c] !== e_pc) begin
                errors++;
                $display("FAIL lduse_pc c%0d: got %0d expected %0d", c, pc_t[c], e_pc);
            end
        end
    endtask

    task automatic test_branch_taken();
        logic e_en;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        logic [7:0] e_pc;
        clear_prog();
        prog_buf[0]  = 32'h10000002;  // BEQ  r0,r0,+2 -> 3
        prog_buf[1]  = 32'h200C0001;  // ADDI r12 (squashed)
        prog_buf[2]  = 32'h200D0002;  // ADDI r13 (squashed)
        prog_buf[3]  = 32'h200E0003;  // ADDI r14,r0,3
        prog_buf[4]  = 32'h1021000A;  // BEQ  r1,r1,+10 -> 15
        prog_buf[5]  = 32'h20100005;  // ADDI r16 (squashed)
        prog_buf[6]  = 32'h20110006;  // ADDI r17 (squashed)
        prog_buf[15] = 32'h20120012;  // ADDI r18,r0,0x12
        load_prog();
        start_run();
        run_trace(12);
        for (int c = 0; c < 12; c++) begin
            case (c)
                7:       begin e_en = 1'b1; e_addr = 5'd14; e_data = 32'd3;  end
                11:      begin e_en = 1'b1; e_addr = 5'd18; e_data = 32'h12; end
                default: begin e_en = 1'b0; e_addr = 5'd0;  e_data = 32'd0;  end
            endcase
            e_pc = (c <= 6) ? 8'(c) : 8'(c + 8);
            checks++;
            if (en_t[c] !== e_en || (e_en && (addr_t[c] !== e_addr || data_t[c] !== e_data))) begin
                errors++;
                $display("FAIL branch_wb c%0d: got en=%0b addr=%0d data=%0h, expected en=%0b addr=%0d data=%0h",
                         c, en_t[c], addr_t[c], data_t[c], e_en, e_addr, e_data);
            end
            checks++;
            if (pc_t[c] !== e_pc) begin
                errors++;
                $display("FAIL branch_pc c%0d: got %0d expected %0d", c, pc_t[c], e_pc);
            end
        end
    endtask

    task automatic test_hold_resume();
        logic e_en;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        clear_prog();
        prog_buf[0] = 32'h20050007;
        prog_buf[1] = 32'h00A53004;
        prog_buf[2] = 32'h00C53804;
        load_prog();
        start_run();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        bus.ProgMode  = 1'b0;
        bus.Addr_Prog = 8'd5;
        bus.Data_Prog = 32'h20140099;  // ADDI r20,r0,0x99
        @(posedge clk);
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            checks++;
            if (bus.pc_out !== 8'd0 || bus.wb_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen h%0d: got pc=%0d en=%0b, expected pc=0 en=0",
                         h, bus.pc_out, bus.wb_en);
            end
            @(posedge clk);
        end
        #1;
        bus.ProgMode = 1'b1;
        run_trace(10);
        for (int c = 0; c < 10; c++) begin
            case (c)
                4:       begin e_en = 1'b1; e_addr = 5'd5;  e_data = 32'd7;  end
                5:       begin e_en = 1'b1; e_addr = 5'd6;  e_data = 32'd14; end
                6:       begin e_en = 1'b1; e_addr = 5'd7;  e_data = 32'd21; end
                9:       begin e_en = 1'b1; e_addr = 5'd20; e_data = 32'h99; end
                default: begin e_en = 1'b0; e_addr = 5'd0;  e_data = 32'd0;  end
            endcase
            checks++;
            if (en_t[c] !== e_en || (e_en && (addr_t[c] !== e_addr || data_t[c] !== e_data))) begin
                errors++;
                $display("FAIL resume_wb c%0d: got en=%0b addr=%0d data=%0h, expected en=%0b addr=%0d data=%0h",
                         c, en_t[c], addr_t[c], data_t[c], e_en, e_addr, e_data);
            end
        end
    endtask

    task automatic test_mid_run_reset();
        clear_prog();
        prog_buf[0] = 32'h20050007;
        prog_buf[1] = 32'h00A53004;
        prog_buf[2] = 32'h00C53804;
        load_prog();
        start_run();
        run_trace(6);
        checks++;
        if (en_t[5] !== 1'b1 || addr_t[5] !== 5'd6 || data_t[5] !== 32'd14) begin
            errors++;
            $display("FAIL midreset_pre: got en=%0b addr=%0d data=%0d, expected en=1 addr=6 data=14",
                     en_t[5], addr_t[5], data_t[5]);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.pc_out !== 8'd0 || bus.wb_en !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got pc=%0d en=%0b addr=%0d data=%0h, expected all zero",
                     bus.pc_out, bus.wb_en, bus.wb_addr, bus.wb_data);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program_run();
        test_forward_chain();
        test_load_use();
        test_branch_taken();
        test_hold_resume();
        test_mid_run_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_pipeline_core.md
Name: mips_pipeline_core

Overview:
- 32-bit MIPS-subset CPU with a classic 5-stage pipeline: IF, ID, EX, MEM, WB.
- Includes forwarding, load-use stall and branch flush.
- Has a 256-word instruction memory that is loaded over a program port, plus a 256-word data memory.
- Top-level compute block of the DSP SoC; the writeback debug port is the bench's observation point.

Parameters:
- IMEM_DEPTH, 256, instruction words; address width 8.
- DMEM_DEPTH, 256, data words; address width 8.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- ProgMode  in  1  0 = program/hold mode, 1 = run mode.
- Addr_Prog  in  8  instruction-memory write address (program mode).
- Data_Prog  in  32  instruction word to write (program mode).
- pc_out  out  8  current IF-stage PC, word address.
- wb_en  out  1  register write occurring this cycle (WB stage).
- wb_addr  out  5  destination register of that write.
- wb_data  out  32  value written.

Behaviour:
- Reset (sampled at posedge):
  - PC=0; all pipeline registers hold NOPs; pc_out=0; wb_en=0; wb_addr=0; wb_data=0.
  - Register file initialised to r[i]=i; r0 reads 0 permanently.
  - Instruction memory and data memory are not cleared.
- Program mode (ProgMode=0, reset=0):
  - Each posedge writes imem[Addr_Prog] <= Data_Prog.
  - Core is frozen in its reset state: PC=0, pipeline NOPs, wb_en=0.
- Run mode (ProgMode=1, reset=0):
  - Imem is write-protected.
  - Fetch imem[PC] each cycle; PC <= PC+1 (8-bit wrap 255->0) unless stalled or redirected.
- Instruction set:
  - R-type, opcode 0x00: rd <= f(rs, rt).
    - funct 0x04 ADD, 0x05 SUB (rs-rt), 0x06 AND, 0x07 OR, 0x08 XOR, 0x09 SLT (signed, result 0/1).
    - Any other funct is a NOP with no write.
  - ADDI 0x08: rt <= rs + sext(imm).
  - LW 0x23: rt <= dmem[(rs+sext(imm))[7:0]].
  - SW 0x2B: dmem[(rs+sext(imm))[7:0]] <= rt.
  - BEQ 0x04: if rs==rt, PC <= PC_of_beq + 1 + imm[7:0].
  - Any other opcode is a NOP.
- Arithmetic: 32-bit, wrap-around, no overflow exceptions.
- Writes to r0: suppressed, and wb_en stays 0.
- Register file is write-before-read: the WB value is visible to ID in the same cycle.
- Forwarding into EX operands, priority EX/MEM over MEM/WB:
  - Applies when the producer writes and its destination is nonzero and matches rs/rt.
  - Also applies to SW store data.
- Load-use hazard (LW in EX, consumer in ID using its rt):
  - Stall PC and IF/ID one cycle; insert a bubble into ID/EX.
- BEQ is resolved in EX:
  - Taken: redirect PC; flush IF/ID and ID/EX to NOPs (2-cycle penalty).
  - Not taken: no penalty.
  - A taken branch overrides a simultaneous load-use stall.
- Latency: instruction fetched in cycle n shows on wb_* in cycle n+4 when there are no stalls.
- Reset asserted mid-run: returns to reset state on the next edge.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ;
  - funct constants: FN_ADD … FN_SLT;
  - ALU op enum;
  - pipeline-register structs: if_id_t, id_ex_t, ex_mem_t, mem_wb_t.
- One natural sub-module: mips_hazard_unit, containing the forwarding selects, stall and flush.
- ALU and register file may stay inline.

Test Plan:
- Load, then run: in program mode write imem[0..4] = 10200005, 10400003, 00000004, 00811005, 00211004; reset; set ProgMode=1; release reset (first run cycle = c0).
  - BEQ r1,r0 and BEQ r2,r0 are not taken.
  - Instruction at index 2 writes r0, so wb_en=0.
  - c7: wb_en=1, wb_addr=2, wb_data=3.
  - c8: wb_en=1, wb_addr=2, wb_data=2.
  - pc_out increments every cycle.
- Forward chain: ADDI r5,r0,7; ADD r6,r5,r5; ADD r7,r6,r5 -> WB values 7, 14, 21 in consecutive cycles, with no stall.
- Load-use: SW r3,0(r0); LW r8,0(r0); ADD r9,r8,r8 -> r9=6, with one bubble cycle of wb_en=0 before r9's write.
- Taken branch: BEQ r0,r0,+2 at PC 0 -> the next two sequential instructions produce no wb_en; execution resumes at PC 3.
- Hold/reset: ProgMode=0 during a run -> pc_out=0 and wb_en=0 while held; imem writes occur; asserting reset mid-run zeroes all outputs on the next edge.
